// File: rtl/fetch_seq_if.sv
// Instruction-memory byte port for fetch_seq.
// master: the fetch sequencer (issues requests); slave: the memory (acks).
interface fetch_seq_if #(
  parameter int N = 64
);
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_ack;
  logic [7:0]   imem_data;
  logic         imem_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_data, imem_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_data, imem_err
  );
endinterface

// File: rtl/fetch_seq.sv
// Byte-serial Y86-64 instruction fetch sequencer.
// Reads one instruction byte per req/ack, decodes icode/ifun/rA/rB/valC,
// computes valP and flags illegal encodings and memory faults.
// Optional per-byte ack watchdog: define FETCH_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for start; results from the last fetch are held
// FETCH | requesting byte PC+k, capturing it on ack
// DONE  | one-cycle done pulse, results valid
module fetch_seq #(
  parameter int N = 64
`ifdef FETCH_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [N-1:0]      i_pc,
  fetch_seq_if.master       imem,
  output logic              o_busy,
  output logic              o_done,
  output logic [3:0]        o_icode,
  output logic [3:0]        o_ifun,
  output logic [3:0]        o_ra,
  output logic [3:0]        o_rb,
  output logic [63:0]       o_valc,
  output logic [N-1:0]      o_valp,
  output logic              o_instr_valid,
  output logic              o_imem_error
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

  state_t       r_state, w_next;
  logic [N-1:0] r_pc;
  logic [3:0]   r_k;
  logic [3:0]   r_len;
  logic [3:0]   r_icode, r_ifun, r_ra, r_rb;
  logic [63:0]  r_valc;
  logic [N-1:0] r_valp;
  logic         r_valid, r_err;

  logic         w_fetch, w_ack, w_good, w_abort, w_timeout, w_last;
  logic [3:0]   w_len0;
  logic         w_valid0;
  logic [2:0]   w_j10, w_j9;

  function automatic logic [3:0] f_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:        f_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:  f_len = 4'd2;
      4'h3, 4'h4, 4'h5:        f_len = 4'd10;
      4'h7, 4'h8:              f_len = 4'd9;
      default:                 f_len = 4'd1;
    endcase
  endfunction

  function automatic logic f_valid(input logic [3:0] ic, input logic [3:0] fn);
    if (ic > 4'hB)                     f_valid = 1'b0;
    else if (ic == 4'h2 || ic == 4'h7) f_valid = (fn <= 4'd6);
    else if (ic == 4'h6)               f_valid = (fn <= 4'd3);
    else                               f_valid = (fn == 4'd0);
  endfunction

  assign w_fetch  = (r_state == S_FETCH);
  assign w_ack    = w_fetch && imem.imem_ack;
  assign w_good   = w_ack && !imem.imem_err;
  assign w_abort  = (w_ack && imem.imem_err) || w_timeout;
  assign w_len0   = f_len(imem.imem_data[7:4]);
  assign w_valid0 = f_valid(imem.imem_data[7:4], imem.imem_data[3:0]);
  // An illegal first byte ends the fetch immediately.
  assign w_last   = w_good && ((r_k == 4'd0) ? (w_len0 == 4'd1 || !w_valid0)
                                             : (r_k + 4'd1 == r_len));
  assign w_j10    = 3'(r_k - 4'd2);
  assign w_j9     = 3'(r_k - 4'd1);

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wait;

  // Per-byte ack watchdog: reload on start and every ack, count down while waiting.
  always_ff @(posedge clk) begin
    if (reset)
      r_wait <= '0;
    else if ((r_state == S_IDLE && i_start) || w_ack)
      r_wait <= TW'(TIMEOUT - 1);
    else if (w_fetch && r_wait != '0)
      r_wait <= r_wait - TW'(1);
  end

  assign w_timeout = w_fetch && !imem.imem_ack && (r_wait == '0);
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_FETCH;
      S_FETCH: if (w_abort || w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Fetch datapath: latch PC, capture bytes into fields, finish valP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= '0;
      r_k     <= '0;
      r_len   <= '0;
      r_icode <= '0;
      r_ifun  <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_valc  <= '0;
      r_valp  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (r_state == S_IDLE && i_start) begin
      r_pc    <= i_pc;
      r_k     <= '0;
      r_len   <= '0;
      r_icode <= '0;
      r_ifun  <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_valc  <= '0;
      r_valp  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_fetch) begin
      if (w_abort) begin
        r_err   <= 1'b1;
        r_valid <= 1'b0;
        r_valp  <= r_pc + N'(r_k);
      end else if (w_good) begin
        r_k <= r_k + 4'd1;
        if (r_k == 4'd0) begin
          r_icode <= imem.imem_data[7:4];
          r_ifun  <= imem.imem_data[3:0];
          r_len   <= w_len0;
          r_valid <= w_valid0;
        end
        if (r_k == 4'd1 && (r_len == 4'd2 || r_len == 4'd10)) begin
          r_ra <= imem.imem_data[7:4];
          r_rb <= imem.imem_data[3:0];
        end
        // Length 10 carries valC in bytes 2..9, length 9 in bytes 1..8.
        if (r_len == 4'd10 && r_k >= 4'd2)
          r_valc[{w_j10, 3'b000} +: 8] <= imem.imem_data;
        if (r_len == 4'd9 && r_k >= 4'd1)
          r_valc[{w_j9, 3'b000} +: 8] <= imem.imem_data;
        if (w_last)
          r_valp <= r_pc + N'((r_k == 4'd0) ? w_len0 : r_len);
      end
    end
  end

  assign imem.imem_req  = w_fetch;
  assign imem.imem_addr = w_fetch ? (r_pc + N'(r_k)) : '0;
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_DONE);
  assign o_icode        = r_icode;
  assign o_ifun         = r_ifun;
  assign o_ra           = r_ra;
  assign o_rb           = r_rb;
  assign o_valc         = r_valc;
  assign o_valp         = r_valp;
  assign o_instr_valid  = r_valid;
  assign o_imem_error   = r_err;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: vector table plus hand-written corner sequences.
module tb_fetch_seq;

  localparam logic [63:0] NONE = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] pc = '0;
  logic        busy, done;
  logic [3:0]  icode, ifun, ra, rb;
  logic [63:0] valc, valp;
  logic        instr_valid, imem_error;

  fetch_seq_if #(.N(64)) m_if ();

  fetch_seq dut (
    .clk(clk), .reset(reset), .i_start(start), .i_pc(pc), .imem(m_if),
    .o_busy(busy), .o_done(done), .o_icode(icode), .o_ifun(ifun),
    .o_ra(ra), .o_rb(rb), .o_valc(valc), .o_valp(valp),
    .o_instr_valid(instr_valid), .o_imem_error(imem_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // memory model configuration
  logic [63:0] cur_pc = '0;
  logic [79:0] cur_bytes = '0;
  int          cur_wait = 0;
  logic [63:0] stall_idx = NONE;
  logic [63:0] err_idx = NONE;
  int          n_req = 0;
  logic [63:0] addr_log[$];
  int          wcnt = 0;
  logic        prev_wait = 1'b0;
  logic [63:0] prev_addr = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory responder: decides ack/data/err on the falling edge for the next rising edge.
  always @(negedge clk) begin
    logic [63:0] idx;
    if (m_if.imem_req) begin
      idx = m_if.imem_addr - cur_pc;
      if (prev_wait) chk("addr_stable", m_if.imem_addr, prev_addr);
      if (idx == stall_idx || wcnt < cur_wait) begin
        m_if.imem_ack = 1'b0;
        m_if.imem_err = 1'b0;
        wcnt++;
        prev_wait = 1'b1;
        prev_addr = m_if.imem_addr;
      end else begin
        m_if.imem_ack  = 1'b1;
        m_if.imem_data = (idx < 64'd10) ? cur_bytes[int'(idx[3:0]) * 8 +: 8] : 8'h00;
        m_if.imem_err  = (idx == err_idx);
        wcnt = 0;
        prev_wait = 1'b0;
        n_req++;
        addr_log.push_back(m_if.imem_addr);
      end
    end else begin
      m_if.imem_ack = 1'b0;
      m_if.imem_err = 1'b0;
      wcnt = 0;
      prev_wait = 1'b0;
    end
  end

  task automatic setup(input logic [63:0] p, input logic [79:0] b);
    cur_pc = p;
    cur_bytes = b;
    cur_wait = 0;
    stall_idx = NONE;
    err_idx = NONE;
    n_req = 0;
    addr_log.delete();
  endtask

  task automatic do_start(input logic [63:0] p);
    @(negedge clk);
    #1 start = 1'b1;
    pc = p;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts cycles after the start edge until done; cycle 1 also checks the first request.
  task automatic wait_done(input string nm, input logic [63:0] p, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk({nm, ".busy1"}, 64'(busy), 64'd1);
        chk({nm, ".req1"}, 64'(m_if.imem_req), 64'd1);
        chk({nm, ".addr1"}, m_if.imem_addr, p);
      end
      if (done) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) begin
      n_bad++;
      $display("FAIL %s.timeout: no done within 60 cycles", nm);
    end
  endtask

  typedef struct {
    logic [63:0] pc;
    logic [79:0] bytes;
    logic [3:0]  ic, fn, ra, rb;
    logic [63:0] valc, valp;
    logic        chk_valp;
    logic        valid;
    int          cyc;
    int          nreq;
    logic [63:0] a1;
  } vec_t;

  vec_t vt[16];

  initial begin
    int cyc;
    string nm;

    vt[0]  = '{64'h100, 80'h01_02_03_04_05_06_07_08_F3_30, 4'h3, 4'h0, 4'hF, 4'h3,
               64'h0102030405060708, 64'h10A, 1'b1, 1'b1, 11, 10, 64'h101};
    vt[1]  = '{64'h40, 80'h90, 4'h9, 4'h0, 4'h0, 4'h0, 64'h0, 64'h41, 1'b1, 1'b1, 2, 1, 64'h0};
    vt[2]  = '{64'h0, 80'hC0, 4'hC, 4'h0, 4'h0, 4'h0, 64'h0, 64'h1, 1'b1, 1'b0, 2, 1, 64'h0};
    vt[3]  = '{64'h10, 80'h00_65, 4'h6, 4'h5, 4'h0, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0, 2, 1, 64'h0};
    vt[4]  = '{64'h200, 80'h00_88_77_66_55_44_33_22_11_80, 4'h8, 4'h0, 4'h0, 4'h0,
               64'h8877665544332211, 64'h209, 1'b1, 1'b1, 10, 9, 64'h201};
    vt[5]  = '{NONE, 80'h10, 4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 1'b1, 1'b1, 2, 1, 64'h0};
    vt[6]  = '{NONE, 80'h12_20, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h1, 1'b1, 1'b1, 3, 2, 64'h0};
    vt[7]  = '{64'h300, 80'h23_61, 4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'h302, 1'b1, 1'b1, 3, 2, 64'h301};
    vt[8]  = '{64'h500, 80'h00_00_00_00_00_00_00_0A_BC_74, 4'h7, 4'h4, 4'h0, 4'h0,
               64'hABC, 64'h509, 1'b1, 1'b1, 10, 9, 64'h501};
    vt[9]  = '{64'h1000, 80'hFF_FF_FF_FF_FF_FF_FF_F8_45_50, 4'h5, 4'h0, 4'h4, 4'h5,
               64'hFFFF_FFFF_FFFF_FFF8, 64'h100A, 1'b1, 1'b1, 11, 10, 64'h1001};
    vt[10] = '{64'h20, 80'h00, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h21, 1'b1, 1'b1, 2, 1, 64'h0};
    vt[11] = '{64'h30, 80'h00_27, 4'h2, 4'h7, 4'h0, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0, 2, 1, 64'h0};
    vt[12] = '{64'h30, 80'h45_26, 4'h2, 4'h6, 4'h4, 4'h5, 64'h0, 64'h32, 1'b1, 1'b1, 3, 2, 64'h31};
    vt[13] = '{64'h50, 80'h4F_A0, 4'hA, 4'h0, 4'h4, 4'hF, 64'h0, 64'h52, 1'b1, 1'b1, 3, 2, 64'h51};
    vt[14] = '{64'h60, 80'h11, 4'h1, 4'h1, 4'h0, 4'h0, 64'h0, 64'h61, 1'b1, 1'b0, 2, 1, 64'h0};
    vt[15] = '{64'h70, 80'h00_64, 4'h6, 4'h4, 4'h0, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0, 2, 1, 64'h0};

    m_if.imem_ack = 1'b0;
    m_if.imem_data = 8'h00;
    m_if.imem_err = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst.req", 64'(m_if.imem_req), 64'd0);
    chk("rst.addr", m_if.imem_addr, 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.fields", {40'd0, icode, ifun, ra, rb, 6'd0, instr_valid, imem_error}, 64'd0);
    chk("rst.valc", valc, 64'd0);
    chk("rst.valp", valp, 64'd0);

    // vector table, zero-wait memory
    for (int v = 0; v < 16; v++) begin
      nm = $sformatf("v%0d", v);
      setup(vt[v].pc, vt[v].bytes);
      do_start(vt[v].pc);
      wait_done(nm, vt[v].pc, cyc);
      chk({nm, ".cyc"}, 64'(cyc), 64'(vt[v].cyc));
      chk({nm, ".icode"}, 64'(icode), 64'(vt[v].ic));
      chk({nm, ".ifun"}, 64'(ifun), 64'(vt[v].fn));
      chk({nm, ".rA"}, 64'(ra), 64'(vt[v].ra));
      chk({nm, ".rB"}, 64'(rb), 64'(vt[v].rb));
      chk({nm, ".valC"}, valc, vt[v].valc);
      if (vt[v].chk_valp) chk({nm, ".valP"}, valp, vt[v].valp);
      chk({nm, ".valid"}, 64'(instr_valid), 64'(vt[v].valid));
      chk({nm, ".err"}, 64'(imem_error), 64'd0);
      chk({nm, ".nreq"}, 64'(n_req), 64'(vt[v].nreq));
      if (addr_log.size() >= 2) begin
        if (vt[v].pc == NONE) chk({nm, ".a1wrap"}, addr_log[1], 64'd0);
        else chk({nm, ".a1"}, addr_log[1], vt[v].a1);
      end
      @(negedge clk);
      chk({nm, ".done_pulse"}, 64'(done), 64'd0);
      chk({nm, ".busy_fall"}, 64'(busy), 64'd0);
    end

    // ret with three wait cycles
    setup(64'h40, 80'h90);
    cur_wait = 3;
    do_start(64'h40);
    wait_done("wait", 64'h40, cyc);
    chk("wait.cyc", 64'(cyc), 64'd5);
    chk("wait.valp", valp, 64'h41);
    chk("wait.valid", 64'(instr_valid), 64'd1);

    // call with fault on byte 2
    setup(64'h200, vt[4].bytes);
    err_idx = 64'd2;
    do_start(64'h200);
    wait_done("fault", 64'h200, cyc);
    chk("fault.cyc", 64'(cyc), 64'd4);
    chk("fault.err", 64'(imem_error), 64'd1);
    chk("fault.valid", 64'(instr_valid), 64'd0);
    chk("fault.valp", valp, 64'h202);
    chk("fault.icode", 64'(icode), 64'h8);
    chk("fault.valc", valc, 64'h11);

`ifdef FETCH_TIMEOUT_EN
    // call with byte 2 never acknowledged
    setup(64'h200, vt[4].bytes);
    stall_idx = 64'd2;
    do_start(64'h200);
    wait_done("tmo", 64'h200, cyc);
    chk("tmo.cyc", 64'(cyc), 64'd18);
    chk("tmo.err", 64'(imem_error), 64'd1);
    chk("tmo.valid", 64'(instr_valid), 64'd0);
    chk("tmo.valp", valp, 64'h202);
    chk("tmo.valc", valc, 64'h11);
`endif

    // start while busy is ignored; results hold after done
    setup(64'h100, vt[0].bytes);
    do_start(64'h100);
    cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 3) begin
        #1 start = 1'b1;
        pc = 64'h999;
      end
      if (i == 4) begin
        #1 start = 1'b0;
        pc = 64'h0;
      end
      if (done) begin
        cyc = i;
        break;
      end
    end
    chk("busy_start.cyc", 64'(cyc), 64'd11);
    chk("busy_start.valp", valp, 64'h10A);
    chk("busy_start.valc", valc, 64'h0102030405060708);
    repeat (3) @(negedge clk);
    chk("hold.valp", valp, 64'h10A);
    chk("hold.icode", 64'(icode), 64'h3);
    chk("hold.done", 64'(done), 64'd0);
    chk("hold.busy", 64'(busy), 64'd0);

    // reset in FETCH after four bytes
    setup(64'h100, vt[0].bytes);
    do_start(64'h100);
    repeat (5) @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst.req", 64'(m_if.imem_req), 64'd0);
    chk("midrst.addr", m_if.imem_addr, 64'd0);
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.done", 64'(done), 64'd0);
    chk("midrst.fields", {40'd0, icode, ifun, ra, rb, 6'd0, instr_valid, imem_error}, 64'd0);
    chk("midrst.valc", valc, 64'd0);
    chk("midrst.valp", valp, 64'd0);

    // clean fetch after reset
    setup(64'h40, 80'h90);
    do_start(64'h40);
    wait_done("post", 64'h40, cyc);
    chk("post.cyc", 64'(cyc), 64'd2);
    chk("post.valp", valp, 64'h41);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
